ipsum_fifo_ctrl: RTL
====================

# ipsum_fifo_ctrl

Read-side FIFO controller for the token engine: fetches a programmed number of 16-bit input partial sums from the GLB through the shared arbiter and pushes them into the ipsum FIFO. The PE array drains that FIFO. It is the GLB-read counterpart of the opsum write path. It issues halfword-addressed read requests and extracts the correct 16-bit lane from each returned 32-bit GLB word. It also bounds arbiter occupancy with a burst limit and never overflows the FIFO.

## Interface
Parameters:
- BURST_MAX, 4, max consecutive arbiter grants before `ipsum_read_req_o` must drop for one cycle

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ipsum_fifo_reset_i  in  1  synchronous soft reset from L2; returns to IDLE and clears counters
- ipsum_need_pop_i  in  1  start command from L2, sampled in IDLE only
- ipsum_pop_num_i  in  32  number of 16-bit elements to load, latched at start
- ipsum_glb_base_addr_i  in  32  GLB byte base address
- ipsum_fifo_pop_mask_i  in  1  PE-side FIFO enable
- pe_array_move_i  in  1  PE array consumes this cycle
- ipsum_permit_push_i  in  1  arbiter grant; GLB read issued this cycle
- ipsum_glb_read_data_i  in  32  GLB read data, valid 1 cycle after grant
- ipsum_fifo_full_i  in  1  FIFO full
- ipsum_fifo_almost_full_i  in  1  FIFO has ≤1 free slot
- ipsum_fifo_empty_i  in  1  FIFO empty
- ipsum_read_req_o  out  1  arbiter request
- ipsum_glb_read_addr_o  out  32  GLB byte address
- ipsum_fifo_push_o  out  1  FIFO push
- ipsum_fifo_push_data_o  out  16  FIFO push data
- ipsum_fifo_pop_o  out  1  FIFO pop to PE array
- ipsum_fifo_done_o  out  1  all elements pushed

## Operation
- FSM states and transitions:
  - IDLE → READ on `ipsum_need_pop_i` when num≠0.
  - IDLE → DONE on `ipsum_need_pop_i` when num=0.
  - READ → DONE in the cycle of the final push (push_o && push_cnt==num−1).
  - DONE holds; `ipsum_need_pop_i` is ignored in DONE.
  - Any state → IDLE on `ipsum_fifo_reset_i`; reset has priority over every other event.
- Counters are 32-bit and cleared by rst_n or fifo_reset:
  - issue_cnt increments on each accepted grant.
  - push_cnt increments on each push.
- ipsum_glb_read_addr_o = base + (issue_cnt << 1), mod 2^32, combinational.
- ipsum_read_req_o = READ && issue_cnt<num && !almost_full && burst_cnt<BURST_MAX && !fifo_reset.
- Grant is accepted only when req_o=1. A grant with req_o=0 is ignored.
- burst_cnt increments on each accepted grant and clears in any cycle with req_o=0.
- On an accepted grant, register inflight=1 and half_sel=addr[1].
- Next cycle, push_o=inflight:
  - half_sel=0 selects data[15:0]; half_sel=1 selects data[31:16].
  - push_data_o=16'h0 whenever push_o=0.
- At most one read is in flight. Because a request requires ≥2 free slots, the FIFO never overflows. If push_o is asserted while full_i=1, that is a protocol error to be flagged by an assertion.
- ipsum_fifo_pop_o = pop_mask && pe_array_move && !empty, independent of FSM state.
- ipsum_fifo_done_o = (state==DONE).

## Timing
- Reset values:
  - state IDLE; all counters 0; inflight 0; half_sel 0.
  - req_o 0, push_o 0, push_data_o 0, done_o 0.
  - addr_o = base.
- Start-to-first-request latency: start at cycle t, req_o high at t+1 if almost_full=0.
- Grant at t → push_o at t+1. Back-to-back grants give one push per cycle.
- Burst limit: after BURST_MAX consecutive grants, req_o is low for exactly one cycle, then reasserts.
- Final push at t → done_o high at t+1.
- fifo_reset with a read in flight: inflight is cleared, and no push occurs in the following cycle.
- Reset at the same cycle as a grant: the grant is dropped.
- A pop and a push in the same cycle are legal.

## Test plan
- base=0x100, num=3, grant held high, FIFO empty:
  - addrs 0x100, 0x102, 0x104.
  - data 0xBBBBAAAA, 0xBBBBAAAA, 0xDDDDCCCC → pushes 0xAAAA, 0xBBBB, 0xCCCC.
  - done_o rises the cycle after the third push.
- num=10, grant held high: grants in cycles 1–4, req_o low in cycle 5, grants again from cycle 6; 10 pushes total.
- FIFO depth 4, no PE pops: req_o drops when almost_full=1, with no push while full.
  - Enabling mask+move then resumes requests.
  - All num=8 elements are delivered in order.
- num=0 start → done_o=1 one cycle later, with no req_o or push_o.
- num=5: assert fifo_reset the cycle after the 2nd grant → no push that cycle, state IDLE, addr_o=base.
  - A restart with num=2 reads from base again.
- DONE state:
  - need_pop is ignored.
  - A spurious grant while req_o=0 produces no push and no counter change.

Source files
------------

// File: rtl/ipsum_fifo_ctrl.sv
// ipsum_fifo_ctrl
// Read-side FIFO controller for the token engine. It fetches a programmed
// number of 16-bit input partial sums from the GLB through the shared arbiter
// and pushes them into the ipsum FIFO, which the PE array drains.
// Each GLB read is halfword addressed, and the matching 16-bit lane is taken
// from the returned 32-bit word. Arbiter occupancy is bounded by a burst limit.
// A read is only requested with at least two free FIFO slots, and at most one
// read is in flight, so the FIFO cannot overflow.

module ipsum_fifo_ctrl #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ipsum_fifo_reset_i,
    input  logic        ipsum_need_pop_i,
    input  logic [31:0] ipsum_pop_num_i,
    input  logic [31:0] ipsum_glb_base_addr_i,
    input  logic        ipsum_fifo_pop_mask_i,
    input  logic        pe_array_move_i,
    input  logic        ipsum_permit_push_i,
    input  logic [31:0] ipsum_glb_read_data_i,
    input  logic        ipsum_fifo_full_i,
    input  logic        ipsum_fifo_almost_full_i,
    input  logic        ipsum_fifo_empty_i,
    output logic        ipsum_read_req_o,
    output logic [31:0] ipsum_glb_read_addr_o,
    output logic        ipsum_fifo_push_o,
    output logic [15:0] ipsum_fifo_push_data_o,
    output logic        ipsum_fifo_pop_o,
    output logic        ipsum_fifo_done_o
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     num_q;
    logic [31:0]     issue_cnt;
    logic [31:0]     push_cnt;
    logic [BW-1:0]   burst_cnt;
    logic            inflight;
    logic            half_sel;
    logic            grant;
    logic            last_push;

    // The read address walks forward one halfword per accepted grant.
    assign ipsum_glb_read_addr_o = ipsum_glb_base_addr_i + {issue_cnt[30:0], 1'b0};

    // Request only while elements remain, the FIFO has at least two free slots,
    // and the burst budget is not exhausted. A soft reset also suppresses requests.
    assign ipsum_read_req_o = (state == READ) && (issue_cnt < num_q)
                              && !ipsum_fifo_almost_full_i
                              && (burst_cnt < BURST_LIM)
                              && !ipsum_fifo_reset_i;

    // A grant counts only when a request was actually outstanding.
    assign grant = ipsum_permit_push_i && ipsum_read_req_o;

    // Data returns one cycle after the grant. A soft reset in that cycle discards the data.
    assign ipsum_fifo_push_o      = inflight && !ipsum_fifo_reset_i;
    assign ipsum_fifo_push_data_o = !ipsum_fifo_push_o ? 16'h0 :
                                    (half_sel ? ipsum_glb_read_data_i[31:16]
                                              : ipsum_glb_read_data_i[15:0]);
    assign last_push = ipsum_fifo_push_o && (push_cnt == num_q - 32'd1);

    assign ipsum_fifo_pop_o  = ipsum_fifo_pop_mask_i && pe_array_move_i && !ipsum_fifo_empty_i;
    assign ipsum_fifo_done_o = (state == DONE);

    // Control FSM: latch the element count at start, and finish on the final push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            num_q <= 32'd0;
        end else if (ipsum_fifo_reset_i) begin
            state <= IDLE;
            num_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ipsum_need_pop_i) begin
                        num_q <= ipsum_pop_num_i;
                        state <= (ipsum_pop_num_i == 32'd0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (last_push) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue and push counters track progress through the element list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= 32'd0;
            push_cnt  <= 32'd0;
        end else if (ipsum_fifo_reset_i) begin
            issue_cnt <= 32'd0;
            push_cnt  <= 32'd0;
        end else begin
            if (grant) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (ipsum_fifo_push_o) begin
                push_cnt <= push_cnt + 32'd1;
            end
        end
    end

    // Burst counter: counts consecutive grants and clears on any idle request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (ipsum_fifo_reset_i || !ipsum_read_req_o) begin
            burst_cnt <= '0;
        end else if (grant) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    // Remember that a read is outstanding and which halfword lane it targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            half_sel <= 1'b0;
        end else if (ipsum_fifo_reset_i) begin
            inflight <= 1'b0;
            half_sel <= 1'b0;
        end else begin
            inflight <= grant;
            if (grant) begin
                half_sel <= ipsum_glb_read_addr_o[1];
            end
        end
    end

    // Pushing into a full FIFO means the free-slot guard was violated upstream.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(ipsum_fifo_push_o && ipsum_fifo_full_i));

endmodule
